// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause-22 MDIO target with a 32 x 16 register file.
// MDC is oversampled on the system clock and never used as a clock itself.
// Optional build macro MMD_INDIRECT_EN: reg13/reg14 become the indirect
// MMD access window (DEVAD 2, addresses 4/5/6/8 stored); without it they are
// plain storage and mmd_skew is tied to zero.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] CTRL_DEFAULT = 16'h1140
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic [1:0]  link_speed,
    input  logic        link_duplex,
    output logic [15:0] ctrl_reg,
    output logic        gbit_adv,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [63:0] mmd_skew
);

    localparam int CNT_W = $clog2(PREAMBLE_LEN + 1);
    localparam logic [CNT_W-1:0] ONES_MAX = CNT_W'(PREAMBLE_LEN);

    // Bit positions counted from the start-0 bit (position 0) of a frame.
    localparam logic [5:0] POS_OP_END    = 6'd3;
    localparam logic [5:0] POS_PHYAD_END = 6'd8;
    localparam logic [5:0] POS_REGAD_END = 6'd13;
    localparam logic [5:0] POS_TA1       = 6'd14;
    localparam logic [5:0] POS_LAST      = 6'd31;
    localparam logic [5:0] POS_RELEASE   = 6'd32;

    typedef enum logic [2:0] {
        S_PREAMBLE,
        S_START2,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_SKIP
    } state_t;

    logic           r_mdc_s1, r_mdc_s2, r_mdc_prev;
    logic           r_mdio_s1, r_mdio_s2;
    state_t         r_state;
    logic [CNT_W-1:0] r_ones;
    logic [5:0]     r_pos;
    logic           r_is_read;
    logic           r_op_b1;
    logic           r_ta1;
    logic [4:0]     r_phyad;
    logic [4:0]     r_regad;
    logic [15:0]    r_shift;
    logic           r_oe, r_out;
    logic           r_wr_strobe;
    logic [4:0]     r_wr_addr;
    logic [15:0]    r_wr_data;
    logic [15:0]    r_regs [0:31];

    logic           w_evt;
    logic           w_bit;
    logic           w_commit;
    logic [15:0]    w_commit_data;
    logic           w_soft_rst;
    logic [15:0]    w_status;
    logic [15:0]    w_rd_word;

    assign w_evt         = r_mdc_s2 & ~r_mdc_prev;
    assign w_bit         = r_mdio_s2;
    assign w_commit      = w_evt && (r_state == S_DATA) && !r_is_read && (r_pos == POS_LAST);
    assign w_commit_data = {r_shift[14:0], w_bit};
    assign w_soft_rst    = w_commit && (r_regad == 5'd0) && w_commit_data[15];
    assign w_status      = {9'b0, link_speed, 1'b0, link_duplex, 3'b0};

`ifdef MMD_INDIRECT_EN
    logic [15:0] r_mmd [0:3];
    logic        w_mmd_data_mode;
    logic        w_mmd_hit;
    logic [1:0]  w_mmd_idx;

    assign w_mmd_data_mode = (r_regs[13][15:14] != 2'b00);
    assign mmd_skew        = {r_mmd[3], r_mmd[2], r_mmd[1], r_mmd[0]};

    // Decode the selected DEVAD/address into one of the four stored MMD words
    always_comb begin
        w_mmd_hit = 1'b0;
        w_mmd_idx = 2'd0;
        if (r_regs[13][4:0] == 5'd2) begin
            case (r_regs[14])
                16'd4:   begin w_mmd_hit = 1'b1; w_mmd_idx = 2'd0; end
                16'd5:   begin w_mmd_hit = 1'b1; w_mmd_idx = 2'd1; end
                16'd6:   begin w_mmd_hit = 1'b1; w_mmd_idx = 2'd2; end
                16'd8:   begin w_mmd_hit = 1'b1; w_mmd_idx = 2'd3; end
                default: begin w_mmd_hit = 1'b0; w_mmd_idx = 2'd0; end
            endcase
        end
    end
`else
    assign mmd_skew = 64'h0;
`endif

    // Read word selection: live status for reg31, MMD window for reg14 in data mode
    always_comb begin
        w_rd_word = r_regs[r_regad];
`ifdef MMD_INDIRECT_EN
        if ((r_regad == 5'd14) && w_mmd_data_mode)
            w_rd_word = w_mmd_hit ? r_mmd[w_mmd_idx] : 16'h0;
`endif
        if (r_regad == 5'd31)
            w_rd_word = w_status;
    end

    // Two-flop synchronizers for mdc and mdio_in plus mdc edge history
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mdc_s1   <= 1'b0;
            r_mdc_s2   <= 1'b0;
            r_mdc_prev <= 1'b0;
            r_mdio_s1  <= 1'b0;
            r_mdio_s2  <= 1'b0;
        end else begin
            r_mdc_s1   <= mdc;
            r_mdc_s2   <= r_mdc_s1;
            r_mdc_prev <= r_mdc_s2;
            r_mdio_s1  <= mdio_in;
            r_mdio_s2  <= r_mdio_s1;
        end
    end

    // Frame FSM: advances only on bit events; owns the pad and write-report outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_PREAMBLE;
            r_ones      <= '0;
            r_pos       <= '0;
            r_is_read   <= 1'b0;
            r_oe        <= 1'b0;
            r_out       <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= 16'h0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_evt) begin
                r_pos <= r_pos + 6'd1;
                case (r_state)
                    S_PREAMBLE: begin
                        r_pos <= '0;
                        if (w_bit) begin
                            if (r_ones != ONES_MAX)
                                r_ones <= r_ones + CNT_W'(1);
                        end else if (r_ones == ONES_MAX) begin
                            r_state <= S_START2;
                            r_pos   <= 6'd1;
                            r_ones  <= '0;
                        end else begin
                            r_ones <= '0;
                        end
                    end
                    S_START2: begin
                        r_state <= w_bit ? S_OP : S_PREAMBLE;
                    end
                    S_OP: begin
                        if (r_pos != POS_OP_END) begin
                            r_op_b1 <= w_bit;
                        end else begin
                            case ({r_op_b1, w_bit})
                                2'b10:   begin r_is_read <= 1'b1; r_state <= S_PHYAD; end
                                2'b01:   begin r_is_read <= 1'b0; r_state <= S_PHYAD; end
                                default: r_state <= S_SKIP;
                            endcase
                        end
                    end
                    S_PHYAD: begin
                        r_phyad <= {r_phyad[3:0], w_bit};
                        if (r_pos == POS_PHYAD_END)
                            r_state <= S_REGAD;
                    end
                    S_REGAD: begin
                        r_regad <= {r_regad[3:0], w_bit};
                        if (r_pos == POS_REGAD_END)
                            r_state <= (r_phyad == PHY_ADDR) ? S_TA : S_SKIP;
                    end
                    S_TA: begin
                        if (r_pos == POS_TA1) begin
                            r_ta1 <= w_bit;
                        end else if (r_is_read) begin
                            r_oe    <= 1'b1;
                            r_out   <= 1'b0;
                            r_shift <= w_rd_word;
                            r_state <= S_DATA;
                        end else begin
                            r_state <= (r_ta1 && !w_bit) ? S_DATA : S_SKIP;
                        end
                    end
                    S_DATA: begin
                        if (r_is_read) begin
                            if (r_pos == POS_RELEASE) begin
                                r_oe    <= 1'b0;
                                r_out   <= 1'b0;
                                r_state <= S_PREAMBLE;
                            end else begin
                                r_out   <= r_shift[15];
                                r_shift <= {r_shift[14:0], 1'b0};
                            end
                        end else begin
                            r_shift <= w_commit_data;
                            if (r_pos == POS_LAST) begin
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_regad;
                                r_wr_data   <= w_commit_data;
                                r_state     <= S_PREAMBLE;
                            end
                        end
                    end
                    S_SKIP: begin
                        if (r_pos == POS_LAST)
                            r_state <= S_PREAMBLE;
                    end
                    default: r_state <= S_PREAMBLE;
                endcase
            end
        end
    end

    // Register file: hard/soft reset to defaults, otherwise commit frame writes
    always_ff @(posedge clock) begin
        if (reset || w_soft_rst) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 16'h0;
            r_regs[0] <= CTRL_DEFAULT;
`ifdef MMD_INDIRECT_EN
            for (int j = 0; j < 4; j++)
                r_mmd[j] <= 16'h0;
`endif
        end else if (w_commit) begin
            if (r_regad == 5'd31) begin
                // read-only status: write is reported but not stored
            end
`ifdef MMD_INDIRECT_EN
            else if ((r_regad == 5'd14) && w_mmd_data_mode) begin
                if (w_mmd_hit)
                    r_mmd[w_mmd_idx] <= w_commit_data;
            end
`endif
            else begin
                r_regs[r_regad] <= w_commit_data;
            end
        end
    end

    assign mdio_out  = r_out;
    assign mdio_oe   = r_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign ctrl_reg  = r_regs[0];
    assign gbit_adv  = r_regs[9][9];

endmodule
